// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the parity helper.
// Both the transmitter and the future receiver import this package.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Widest supported word; narrower words are zero-extended, which leaves the XOR unchanged.
    localparam int MAX_DATA_BITS = 9;

    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
        case (mode)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~^data;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle
// of each bit. Synchronous clear restarts the bit; shared with the receiver.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bit_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_baud_cnt: CLKS_PER_BIT must be at least 2");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first, optional
// parity, one or two stop bits. Valid/ready input; frames can run back-to-back.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be in 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_frame: CLKS_PER_BIT must be at least 2");
    end
    if (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_EVEN && PARITY_MODE != PAR_ODD) begin : g_bad_parity
        $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam bit HAS_PARITY = (PARITY_MODE != PAR_NONE);

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;

    logic bit_end;
    logic stop_last;
    logic accept;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (state_q != ST_IDLE),
        .bit_end(bit_end)
    );

    assign stop_last = (STOP_BITS == 1) ? 1'b1 : stop_idx_q;
    // Ready also in the final stop cycle so a held tx_valid chains frames with no gap.
    assign tx_ready  = (state_q == ST_IDLE) ||
                       ((state_q == ST_STOP) && stop_last && bit_end);
    assign accept    = tx_valid && tx_ready;
    assign busy      = (state_q != ST_IDLE);
    assign tx        = tx_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        parity_d   = parity_q;

        if (accept) begin
            // Parity comes from the accepted word, before any shifting.
            shift_d    = tx_data;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            parity_d   = parity_bit(MAX_DATA_BITS'(tx_data), PARITY_MODE);
            state_d    = ST_START;
        end else begin
            case (state_q)
                ST_START: begin
                    if (bit_end) begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift_d = shift_q >> 1;
                        if (bit_idx_q == LAST_IDX) begin
                            state_d    = HAS_PARITY ? ST_PARITY : ST_STOP;
                            stop_idx_d = 1'b0;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state_d    = ST_STOP;
                        stop_idx_d = 1'b0;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (stop_last) begin
                            state_d = ST_IDLE;
                        end else begin
                            stop_idx_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output logic: tx is registered, so the line level follows the next state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: five instances covering the parameter corners,
// table-driven frame vectors plus hand-written back-to-back, data-hold and reset sequences.
module tb_uart_tx_frame;

    logic clk = 1'b0;
    logic rst;
    logic tx_valid_i [5];
    logic tx_o       [5];
    logic busy_o     [5];
    logic rdy_o      [5];
    logic [7:0] d0, d1, d2, d3;
    logic [4:0] d4;

    int cpb_of [5] = '{4, 4, 4, 4, 2};

    int total = 0;
    int bad   = 0;
    int rdy_cnt;
    int rdy_pos;
    int busy_low;

    always #5 clk = ~clk;

    // 0: 8N1 cpb4, 1: 8E1 cpb4, 2: 8O1 cpb4, 3: 8E2 cpb4, 4: 5N1 cpb2
    uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .tx_valid(tx_valid_i[0]), .tx_data(d0),
        .tx_ready(rdy_o[0]), .tx(tx_o[0]), .busy(busy_o[0]));
    uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1)) u_b (
        .clk(clk), .rst(rst), .tx_valid(tx_valid_i[1]), .tx_data(d1),
        .tx_ready(rdy_o[1]), .tx(tx_o[1]), .busy(busy_o[1]));
    uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1)) u_c (
        .clk(clk), .rst(rst), .tx_valid(tx_valid_i[2]), .tx_data(d2),
        .tx_ready(rdy_o[2]), .tx(tx_o[2]), .busy(busy_o[2]));
    uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(2)) u_d (
        .clk(clk), .rst(rst), .tx_valid(tx_valid_i[3]), .tx_data(d3),
        .tx_ready(rdy_o[3]), .tx(tx_o[3]), .busy(busy_o[3]));
    uart_tx_frame #(.DATA_BITS(5), .CLKS_PER_BIT(2), .PARITY_MODE(0), .STOP_BITS(1)) u_e (
        .clk(clk), .rst(rst), .tx_valid(tx_valid_i[4]), .tx_data(d4),
        .tx_ready(rdy_o[4]), .tx(tx_o[4]), .busy(busy_o[4]));

    typedef struct {
        int          inst;
        logic [8:0]  data;
        int          nbits;
        logic [15:0] bits;   // bit i = expected line level of serial bit i
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input bit ok, input string what, input int act, input int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", what, act, exp);
        end
    endtask

    task automatic set_data(input int inst, input logic [8:0] d);
        case (inst)
            0: d0 = d[7:0];
            1: d1 = d[7:0];
            2: d2 = d[7:0];
            3: d3 = d[7:0];
            default: d4 = d[4:0];
        endcase
    endtask

    task automatic start_frame(input int inst, input logic [8:0] d, input string name);
        @(negedge clk);
        chk(rdy_o[inst] === 1'b1, {name, " ready before send"}, int'(rdy_o[inst]), 1);
        set_data(inst, d);
        tx_valid_i[inst] = 1'b1;
    endtask

    // Samples nbits*cpb cycles starting with the first negedge after the accept edge.
    task automatic check_bits(input int inst, input logic [15:0] bits, input int nbits,
                              input string name, input bit drop_valid, input bit poke);
        int s;
        int wrong;
        logic seen;
        s = 0;
        rdy_cnt = 0;
        rdy_pos = -1;
        busy_low = 0;
        for (int i = 0; i < nbits; i++) begin
            wrong = 0;
            seen = bits[i];
            for (int c = 0; c < cpb_of[inst]; c++) begin
                @(negedge clk);
                if (tx_o[inst] !== bits[i]) begin
                    wrong++;
                    seen = tx_o[inst];
                end
                if (busy_o[inst] !== 1'b1) busy_low++;
                if (rdy_o[inst] === 1'b1) begin
                    rdy_cnt++;
                    rdy_pos = s;
                end
                if (s == 0 && drop_valid) tx_valid_i[inst] = 1'b0;
                if (poke && s == 8) begin
                    set_data(inst, 9'h1FF);
                    tx_valid_i[inst] = 1'b1;
                end
                if (poke && s == 9) tx_valid_i[inst] = 1'b0;
                s++;
            end
            chk(wrong == 0, $sformatf("%s bit%0d level", name, i), int'(seen), int'(bits[i]));
        end
    endtask

    task automatic frame_stats(input int inst, input int nbits, input string name);
        int f;
        f = nbits * cpb_of[inst];
        chk(rdy_cnt == 1, {name, " ready pulses"}, rdy_cnt, 1);
        chk(rdy_pos == f - 1, {name, " ready cycle"}, rdy_pos, f - 1);
        chk(busy_low == 0, {name, " busy low in frame"}, busy_low, 0);
    endtask

    task automatic idle_after(input int inst, input string name);
        @(negedge clk);
        chk(busy_o[inst] === 1'b0, {name, " busy after frame"}, int'(busy_o[inst]), 0);
        chk(tx_o[inst] === 1'b1, {name, " tx after frame"}, int'(tx_o[inst]), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        vecs[0] = '{0, 9'h0A5, 10, 16'h034A};
        vecs[1] = '{0, 9'h000, 10, 16'h0200};
        vecs[2] = '{0, 9'h0FF, 10, 16'h03FE};
        vecs[3] = '{1, 9'h007, 11, 16'h060E};
        vecs[4] = '{2, 9'h007, 11, 16'h040E};
        vecs[5] = '{1, 9'h001, 11, 16'h0602};
        vecs[6] = '{2, 9'h000, 11, 16'h0600};
        vecs[7] = '{4, 9'h01F, 7,  16'h007E};
        vecs[8] = '{4, 9'h1F5, 7,  16'h006A};
        vecs[9] = '{3, 9'h00F, 12, 16'h0C1E};

        rst = 1'b1;
        for (int i = 0; i < 5; i++) tx_valid_i[i] = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0; d4 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk(tx_o[i] === 1'b1, $sformatf("reset tx inst%0d", i), int'(tx_o[i]), 1);
            chk(busy_o[i] === 1'b0, $sformatf("reset busy inst%0d", i), int'(busy_o[i]), 0);
            chk(rdy_o[i] === 1'b1, $sformatf("reset ready inst%0d", i), int'(rdy_o[i]), 1);
        end

        for (int k = 0; k < 10; k++) begin
            string nm;
            nm = $sformatf("vec%0d", k);
            start_frame(vecs[k].inst, vecs[k].data, nm);
            check_bits(vecs[k].inst, vecs[k].bits, vecs[k].nbits, nm, 1'b1, 1'b0);
            frame_stats(vecs[k].inst, vecs[k].nbits, nm);
            idle_after(vecs[k].inst, nm);
        end

        // Back-to-back 0x55, 0xAA with tx_valid held across the frame boundary.
        start_frame(3, 9'h055, "b2b");
        @(posedge clk);
        #1 set_data(3, 9'h0AA);
        check_bits(3, 16'h0CAA, 12, "b2b first", 1'b0, 1'b0);
        frame_stats(3, 12, "b2b first");
        check_bits(3, 16'h0D54, 12, "b2b second", 1'b1, 1'b0);
        frame_stats(3, 12, "b2b second");
        idle_after(3, "b2b");

        // Input changes and a stray valid pulse mid-frame must not disturb the line.
        start_frame(0, 9'h000, "hold");
        check_bits(0, 16'h0200, 10, "hold", 1'b1, 1'b1);
        frame_stats(0, 10, "hold");
        idle_after(0, "hold");

        // Reset at the third data bit aborts the frame.
        start_frame(0, 9'h000, "abort");
        for (int s = 0; s <= 12; s++) begin
            @(negedge clk);
            if (s == 0) tx_valid_i[0] = 1'b0;
        end
        chk(tx_o[0] === 1'b0, "abort tx before reset", int'(tx_o[0]), 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(tx_o[0] === 1'b1, "abort tx after reset", int'(tx_o[0]), 1);
        chk(busy_o[0] === 1'b0, "abort busy after reset", int'(busy_o[0]), 0);
        chk(rdy_o[0] === 1'b1, "abort ready after reset", int'(rdy_o[0]), 1);

        v = '{0, 9'h03C, 10, 16'h0278};
        start_frame(v.inst, v.data, "post abort");
        check_bits(v.inst, v.bits, v.nbits, "post abort", 1'b1, 1'b0);
        frame_stats(v.inst, v.nbits, "post abort");
        idle_after(v.inst, "post abort");

        // Reset together with tx_valid: the word is dropped.
        @(negedge clk);
        rst = 1'b1;
        set_data(0, 9'h00F);
        tx_valid_i[0] = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        tx_valid_i[0] = 1'b0;
        @(negedge clk);
        chk(busy_o[0] === 1'b0, "rst+valid busy", int'(busy_o[0]), 0);
        chk(tx_o[0] === 1'b1, "rst+valid tx", int'(tx_o[0]), 1);
        repeat (3) @(negedge clk);
        chk(busy_o[0] === 1'b0, "rst+valid busy later", int'(busy_o[0]), 0);
        chk(tx_o[0] === 1'b1, "rst+valid tx later", int'(tx_o[0]), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that serialises one data word per frame: start bit, DATA_BITS data bits LSB first, an optional parity bit, then one or two stop bits. Each bit is held for CLKS_PER_BIT clock cycles. Words are accepted through a valid/ready handshake, and frames can run back-to-back with no idle gap. This block is the next-generation replacement for the fixed 8-bit, one-clock-per-bit transmitter and sits between a producer (FIFO or register interface) and the serial pin.

## Interface
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be at least 2.
- PARITY_MODE, 0, parity bit: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- tx_valid  input  1  producer has a word on tx_data.
- tx_data  input  DATA_BITS  word to send; sampled only on the accept cycle.
- tx_ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line; registered; idles high.
- busy  output  1  a frame is in progress (any state other than IDLE).

## Operation
- States: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PARITY_MODE = 0.
- Accept occurs when tx_valid && tx_ready on the same rising edge. On accept:
  - tx_data goes into the shift register.
  - bit_idx and baud_cnt clear.
  - The parity bit is computed and latched.
  - State moves to START.
- baud_cnt counts 0..CLKS_PER_BIT-1 in every non-IDLE state. The state or bit advances when baud_cnt = CLKS_PER_BIT-1. Counter width is $clog2(CLKS_PER_BIT).
- START: tx = 0 for one bit time, then move to DATA.
- DATA: tx = shift_reg[0]. At each bit end, shift right and increment bit_idx. After bit DATA_BITS-1, move to PARITY (or to STOP if PARITY_MODE = 0).
- PARITY: even mode sends ^data; odd mode sends ~^data. Parity is computed from the accepted word, not from the shifted register.
- STOP: tx = 1 for STOP_BITS bit times. The stop counter advances at each bit end.
- tx_ready = (state == IDLE) || (state == STOP && final stop bit && baud_cnt == CLKS_PER_BIT-1).
  - Accept in that last STOP cycle goes directly to START, giving a back-to-back frame with no gap.
  - With no accept in that cycle, the state goes to IDLE.
- tx_valid and tx_data are ignored while tx_ready = 0. Changes to tx_data after accept do not affect the frame in flight.
- Reset values: state = IDLE, tx = 1, tx_ready = 1, busy = 0, all counters and the shift register = 0.
- Reset asserted mid-frame aborts the frame. tx returns to 1 on the next edge; no partial stop bit is sent.
- Reset asserted together with tx_valid: reset wins and the word is not accepted.
- Illegal parameter values are rejected at elaboration with $error and are not handled at runtime.

## Timing
- tx is registered. The start bit (tx = 0) appears on the first edge after the accept edge.
- Frame length F = (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) × CLKS_PER_BIT cycles.
- busy rises on the edge after accept and stays high for F cycles. It falls only if no back-to-back accept occurred.
- tx_ready drops on the edge after accept. It is high for exactly one cycle per frame during streaming; the producer must hold tx_valid.
- Throughput: one word per F cycles; no idle cycles between frames when tx_valid is held.

## Structure
- Shared package uart_pkg holds:
  - the state encoding localparams (ST_IDLE..ST_STOP);
  - the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD).
  The future receiver reuses this package.
- One sub-module, uart_baud_cnt:
  - a parametrised CLKS_PER_BIT counter with synchronous clear and enable;
  - outputs bit_end;
  - shared with the receiver.
- Everything else (FSM, shift register, stop counter) stays in uart_tx_frame.

## Test plan
- Parameters DATA_BITS=8, CLKS_PER_BIT=4, PARITY_MODE=0, STOP_BITS=1; send 0xA5.
  - tx must be 0,1,0,1,0,0,1,0,1,1, each level held for 4 cycles (40 cycles total).
  - busy must be high for exactly 40 cycles.
- PARITY_MODE=1, send 0x07 → parity bit = 1. PARITY_MODE=2, send 0x07 → parity bit = 0. Frame length 44 cycles in both cases.
- STOP_BITS=2, tx_valid held, words 0x55 then 0xAA.
  - The second start bit must begin exactly 48 cycles after the first.
  - tx_ready is high for one cycle between the frames; the line has no idle gap.
- tx_data changed to 0xFF during the DATA state of a 0x00 frame → all data bits on tx stay 0. A tx_valid pulse while busy is not accepted.
- Assert rst for one cycle at the third data bit.
  - Next edge: tx = 1, busy = 0, tx_ready = 1.
  - A following send of 0x3C completes as a normal frame.
- DATA_BITS=5, CLKS_PER_BIT=2: send 0x1F → tx is start bit, then five 1s, then stop bit (14 cycles). Bits above bit 4 of tx_data are ignored.
